clks_alot_event_generator: RTL and testbench

//  Multi-channel clock-event generator for the Generation stage of clks_alot.

---
 rtl/clks_alot_event_generator_pkg.sv | 28 ++
 rtl/clks_alot_gen_channel.sv | 119 +++++++++++
 rtl/clks_alot_event_generator.sv | 47 ++++
 tb/tb_clks_alot_event_generator.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clks_alot_event_generator_pkg.sv
// Shared types for the clks_alot generation stage: clock/reset bundle, phase states, event record.
// Latency: n/a (types only). Backpressure: n/a.
package common_p;

    typedef struct packed {
        logic clk;
        logic rst_n;
    } clk_dom_s;

endpackage

package clks_alot_p;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } phase_state_e;

    // Field order is part of the interface: {clk, rising, falling, any}.
    typedef struct packed {
        logic clk;
        logic rising;
        logic falling;
        logic any;
    } generated_events_s;

endpackage

// File: rtl/clks_alot_gen_channel.sv
// One generator channel: HIGH/LOW phase FSM with shadowed lengths, lead compare and resync handling.
// Latency: 1 cycle from any input to registered outputs. Backpressure: none, free-running.
module clks_alot_gen_channel
    import clks_alot_p::*;
#(
    parameter int RATE_W = 16,
    parameter int LEAD_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    input  logic [RATE_W-1:0] rate_high_i,
    input  logic [RATE_W-1:0] rate_low_i,
    input  logic [LEAD_W-1:0] lead_i,
    input  logic              resync_i,
    output generated_events_s exp_o,
    output generated_events_s pre_o,
    output logic              slip_o,
    output logic              clamped_o
);

    function automatic logic [RATE_W-1:0] phase_len(input logic [RATE_W-1:0] rate);
        return (rate == '0) ? RATE_W'(1) : rate;
    endfunction

    phase_state_e      state_q, state_d;
    logic [RATE_W-1:0] count_q, count_d;
    logic [RATE_W-1:0] len_q, len_d;
    logic              pre_clk_q, pre_clk_d;
    logic              rise_d, fall_d, slip_d;
    logic              pre_rise_d, pre_fall_d, clamp_d;
    logic [RATE_W-1:0] lead_ext, last_idx, eff_lead;
    generated_events_s exp_q, exp_d, pre_q, pre_d;
    logic              slip_q, clamp_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        slip_d  = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
            count_d = '0;
        end else if (state_q == IDLE || resync_i) begin
            state_d = HIGH;
            len_d   = phase_len(rate_high_i);
            count_d = len_d - RATE_W'(1);
            rise_d  = 1'b1;
            // A resync landing exactly on the natural rising edge is a no-op on phase.
            if (state_q != IDLE && !(state_q == LOW && count_q == '0)) begin
                slip_d = 1'b1;
                fall_d = (state_q == HIGH);
            end
        end else if (count_q == '0) begin
            if (state_q == HIGH) begin
                state_d = LOW;
                len_d   = phase_len(rate_low_i);
                fall_d  = 1'b1;
            end else begin
                state_d = HIGH;
                len_d   = phase_len(rate_high_i);
                rise_d  = 1'b1;
            end
            count_d = len_d - RATE_W'(1);
        end else begin
            count_d = count_q - RATE_W'(1);
        end
    end

    // Preemptive events are evaluated against the phase being entered, so a
    // resync naturally discards anything pending from the aborted phase.
    always_comb begin
        lead_ext   = RATE_W'(lead_i);
        last_idx   = len_d - RATE_W'(1);
        eff_lead   = (lead_ext > last_idx) ? last_idx : lead_ext;
        clamp_d    = (state_d != IDLE) && (lead_ext >= last_idx);
        pre_rise_d = (state_d == LOW)  && (count_d == eff_lead);
        pre_fall_d = (state_d == HIGH) && (count_d == eff_lead);

        pre_clk_d = pre_clk_q;
        if (state_d == IDLE)  pre_clk_d = 1'b0;
        else if (pre_rise_d)  pre_clk_d = 1'b1;
        else if (pre_fall_d)  pre_clk_d = 1'b0;

        exp_d = '{clk: (state_d == HIGH), rising: rise_d, falling: fall_d, any: rise_d | fall_d};
        pre_d = '{clk: pre_clk_d, rising: pre_rise_d, falling: pre_fall_d, any: pre_rise_d | pre_fall_d};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            len_q     <= '0;
            pre_clk_q <= 1'b0;
            exp_q     <= '0;
            pre_q     <= '0;
            slip_q    <= 1'b0;
            clamp_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            len_q     <= len_d;
            pre_clk_q <= pre_clk_d;
            exp_q     <= exp_d;
            pre_q     <= pre_d;
            slip_q    <= slip_d;
            clamp_q   <= clamp_d;
        end
    end

    assign exp_o     = exp_q;
    assign pre_o     = pre_q;
    assign slip_o    = slip_q;
    assign clamped_o = clamp_q;

endmodule

// File: rtl/clks_alot_event_generator.sv
// Multi-channel clock-event generator: independent channels, each synthesising a clock plus lead events.
// Latency: 1 cycle from any input. Backpressure: none, outputs are free-running pulses/levels.
module clks_alot_event_generator
    import clks_alot_p::*;
#(
    parameter int CHANNELS = 4,
    parameter int RATE_W   = 16,
    parameter int LEAD_W   = 8
) (
    input  common_p::clk_dom_s                  sys_dom_i,
    input  logic [CHANNELS-1:0]                 chan_en_i,
    input  logic [CHANNELS-1:0][RATE_W-1:0]     rate_high_i,
    input  logic [CHANNELS-1:0][RATE_W-1:0]     rate_low_i,
    input  logic [CHANNELS-1:0][LEAD_W-1:0]     lead_i,
    input  logic [CHANNELS-1:0]                 resync_i,
    output generated_events_s [CHANNELS-1:0]    expected_clks_o,
    output generated_events_s [CHANNELS-1:0]    preemptive_clks_o,
    output logic [CHANNELS-1:0]                 resync_slip_o,
    output logic [CHANNELS-1:0]                 lead_clamped_o
);

    logic sys_clk;
    logic sys_rst_n;

    assign sys_clk   = sys_dom_i.clk;
    assign sys_rst_n = sys_dom_i.rst_n;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        clks_alot_gen_channel #(
            .RATE_W (RATE_W),
            .LEAD_W (LEAD_W)
        ) u_chan (
            .clk_i       (sys_clk),
            .rst_n_i     (sys_rst_n),
            .en_i        (chan_en_i[ch]),
            .rate_high_i (rate_high_i[ch]),
            .rate_low_i  (rate_low_i[ch]),
            .lead_i      (lead_i[ch]),
            .resync_i    (resync_i[ch]),
            .exp_o       (expected_clks_o[ch]),
            .pre_o       (preemptive_clks_o[ch]),
            .slip_o      (resync_slip_o[ch]),
            .clamped_o   (lead_clamped_o[ch])
        );
    end

endmodule

// File: tb/tb_clks_alot_event_generator.sv
// Directed bench for clks_alot_event_generator: vector table on channel 0 plus resync and multi-channel sequences.
module tb_clks_alot_event_generator;
    import clks_alot_p::*;

    localparam int CH = 4;

    logic                 clk;
    logic                 rst_n;
    common_p::clk_dom_s   sys_dom;
    logic [CH-1:0]        chan_en;
    logic [CH-1:0][15:0]  rate_high;
    logic [CH-1:0][15:0]  rate_low;
    logic [CH-1:0][7:0]   lead;
    logic [CH-1:0]        resync;
    generated_events_s [CH-1:0] exp_clks;
    generated_events_s [CH-1:0] pre_clks;
    logic [CH-1:0]        slip;
    logic [CH-1:0]        clamped;

    int checks;
    int failures;

    assign sys_dom = {clk, rst_n};

    clks_alot_event_generator #(.CHANNELS(CH), .RATE_W(16), .LEAD_W(8)) dut (
        .sys_dom_i         (sys_dom),
        .chan_en_i         (chan_en),
        .rate_high_i       (rate_high),
        .rate_low_i        (rate_low),
        .lead_i            (lead),
        .resync_i          (resync),
        .expected_clks_o   (exp_clks),
        .preemptive_clks_o (pre_clks),
        .resync_slip_o     (slip),
        .lead_clamped_o    (clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [15:0] rh;
        logic [15:0] rl;
        logic [7:0]  ld;
        logic [3:0]  ex;
        logic [3:0]  pr;
        logic        sl;
        logic        cl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic [15:0] rh, input logic [15:0] rl, input logic [7:0] ld,
                       input logic [3:0] ex, input logic [3:0] pr, input logic sl, input logic cl);
        vec_t v;
        v.en = en; v.rh = rh; v.rl = rl; v.ld = ld; v.ex = ex; v.pr = pr; v.sl = sl; v.cl = cl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ch(input string nm, input int ch, input logic [3:0] ex, input logic [3:0] pr,
                          input logic sl, input logic cl);
        chk({nm, "_exp"},   64'(exp_clks[ch]), 64'(ex));
        chk({nm, "_pre"},   64'(pre_clks[ch]), 64'(pr));
        chk({nm, "_slip"},  64'(slip[ch]),     64'(sl));
        chk({nm, "_clamp"}, 64'(clamped[ch]),  64'(cl));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_exp_bus"},   64'(exp_clks), 64'(0));
        chk({nm, "_pre_bus"},   64'(pre_clks), 64'(0));
        chk({nm, "_slip_bus"},  64'(slip),     64'(0));
        chk({nm, "_clamp_bus"}, 64'(clamped),  64'(0));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n     = 1'b0;
        chan_en   = '1;
        rate_high = '{default: 16'd3};
        rate_low  = '{default: 16'd5};
        lead      = '0;
        resync    = '0;

        // Reset held with enables high: nothing may come out.
        repeat (3) step();
        chk_all_zero("reset_hold");
        chan_en = '0;
        rst_n   = 1'b1;
        step();
        chk_all_zero("post_reset_a");
        step();
        chk_all_zero("post_reset_b");

        // Basic generation, rh=3 rl=5 lead=0.
        add(1,3,5,0, 4'b1101,4'b0000,0,0);
        add(1,3,5,0, 4'b1000,4'b0000,0,0);
        add(1,3,5,0, 4'b1000,4'b0011,0,0);
        add(1,3,5,0, 4'b0011,4'b0000,0,0);
        add(1,3,5,0, 4'b0000,4'b0000,0,0);
        add(1,3,5,0, 4'b0000,4'b0000,0,0);
        add(1,3,5,0, 4'b0000,4'b0000,0,0);
        add(1,3,5,0, 4'b0000,4'b1101,0,0);
        add(1,3,5,0, 4'b1101,4'b1000,0,0);
        add(1,3,5,0, 4'b1000,4'b1000,0,0);
        add(1,3,5,0, 4'b1000,4'b0011,0,0);
        add(1,3,5,0, 4'b0011,4'b0000,0,0);
        add(0,3,5,0, 4'b0000,4'b0000,0,0);
        // Lead 2 clamps in HIGH only, then lead 9 clamps in both phases.
        add(1,3,5,2, 4'b1101,4'b0011,0,1);
        add(1,3,5,2, 4'b1000,4'b0000,0,1);
        add(1,3,5,2, 4'b1000,4'b0000,0,1);
        add(1,3,5,2, 4'b0011,4'b0000,0,0);
        add(1,3,5,2, 4'b0000,4'b0000,0,0);
        add(1,3,5,2, 4'b0000,4'b1101,0,0);
        add(1,3,5,2, 4'b0000,4'b1000,0,0);
        add(1,3,5,2, 4'b0000,4'b1000,0,0);
        add(1,3,5,9, 4'b1101,4'b0011,0,1);
        add(1,3,5,9, 4'b1000,4'b0000,0,1);
        add(1,3,5,9, 4'b1000,4'b0000,0,1);
        add(1,3,5,9, 4'b0011,4'b1101,0,1);
        add(1,3,5,9, 4'b0000,4'b1000,0,1);
        add(0,3,5,9, 4'b0000,4'b0000,0,0);
        // rate_high 3->6 mid-HIGH: current high stays 3, next high is 6.
        add(1,3,5,0, 4'b1101,4'b0000,0,0);
        add(1,6,5,0, 4'b1000,4'b0000,0,0);
        add(1,6,5,0, 4'b1000,4'b0011,0,0);
        add(1,6,5,0, 4'b0011,4'b0000,0,0);
        add(1,6,5,0, 4'b0000,4'b0000,0,0);
        add(1,6,5,0, 4'b0000,4'b0000,0,0);
        add(1,6,5,0, 4'b0000,4'b0000,0,0);
        add(1,6,5,0, 4'b0000,4'b1101,0,0);
        add(1,6,5,0, 4'b1101,4'b1000,0,0);
        add(1,6,5,0, 4'b1000,4'b1000,0,0);
        add(1,6,5,0, 4'b1000,4'b1000,0,0);
        add(1,6,5,0, 4'b1000,4'b1000,0,0);
        add(1,6,5,0, 4'b1000,4'b1000,0,0);
        add(1,6,5,0, 4'b1000,4'b0011,0,0);
        add(1,6,5,0, 4'b0011,4'b0000,0,0);
        add(0,6,5,0, 4'b0000,4'b0000,0,0);
        // Zero rates behave as 1-cycle phases.
        add(1,0,0,0, 4'b1101,4'b0011,0,1);
        add(1,0,0,0, 4'b0011,4'b1101,0,1);
        add(1,0,0,0, 4'b1101,4'b0011,0,1);
        add(1,0,0,0, 4'b0011,4'b1101,0,1);
        add(0,0,0,0, 4'b0000,4'b0000,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            chan_en[0]   = vecs[i].en;
            rate_high[0] = vecs[i].rh;
            rate_low[0]  = vecs[i].rl;
            lead[0]      = vecs[i].ld;
            step();
            chk_ch($sformatf("vec%0d", i), 0, vecs[i].ex, vecs[i].pr, vecs[i].sl, vecs[i].cl);
            chk($sformatf("vec%0d_others_idle", i), 64'(exp_clks[3:1]), 64'(0));
        end

        // Resync sequences on channel 0, rh=3 rl=5 lead=0.
        rate_high[0] = 16'd3; rate_low[0] = 16'd5; lead[0] = 8'd0;
        chan_en[0] = 1'b1;
        step();                 // t1
        repeat (4) step();      // t5: LOW, count 3
        chk("rs_midlow_before", 64'(exp_clks[0]), 64'(4'b0000));
        resync[0] = 1'b1;
        step();                 // t6
        resync[0] = 1'b0;
        chk_ch("rs_midlow", 0, 4'b1101, 4'b0000, 1, 0);
        step();                 // t7
        chk_ch("rs_midlow_after", 0, 4'b1000, 4'b0000, 0, 0);
        repeat (6) step();      // t13: LOW, count 0
        chk_ch("rs_aligned_before", 0, 4'b0000, 4'b1101, 0, 0);
        resync[0] = 1'b1;
        step();                 // t14
        chk_ch("rs_aligned", 0, 4'b1101, 4'b1000, 0, 0);
        step();                 // t15: resync again while HIGH
        resync[0] = 1'b0;
        chk_ch("rs_midhigh", 0, 4'b1111, 4'b1000, 1, 0);
        step();
        chk_ch("rs_midhigh_after", 0, 4'b1000, 4'b1000, 0, 0);
        chan_en[0] = 1'b0;
        step();
        resync[0] = 1'b1;
        step();
        chk_ch("rs_disabled", 0, 4'b0000, 4'b0000, 0, 0);
        resync[0] = 1'b0;
        chan_en[0] = 1'b1;
        step();
        chk_ch("rs_reenable", 0, 4'b1101, 4'b0000, 0, 0);
        chan_en[0] = 1'b0;
        step();

        // Four independent channels; channel 2 disabled mid-HIGH then re-enabled.
        rate_high = {16'd1, 16'd4, 16'd2, 16'd3};
        rate_low  = {16'd1, 16'd4, 16'd2, 16'd5};
        lead      = '0;
        chan_en   = 4'b1111;
        step();                 // t1
        for (int c = 0; c < CH; c++) chk($sformatf("mc_t1_ch%0d", c), 64'(exp_clks[c]), 64'(4'b1101));
        step();                 // t2
        chan_en[2] = 1'b0;
        step();                 // t3
        chk_ch("mc_t3_ch2", 2, 4'b0000, 4'b0000, 0, 0);
        chk("mc_t3_ch0", 64'(exp_clks[0]), 64'(4'b1000));
        chk("mc_t3_ch1", 64'(exp_clks[1]), 64'(4'b0011));
        chk("mc_t3_ch3", 64'(exp_clks[3]), 64'(4'b1101));
        chan_en[2] = 1'b1;
        step();                 // t4
        chk("mc_t4_ch2", 64'(exp_clks[2]), 64'(4'b1101));
        chk("mc_t4_ch0", 64'(exp_clks[0]), 64'(4'b0011));
        chk("mc_t4_ch1", 64'(exp_clks[1]), 64'(4'b0000));
        chk("mc_t4_ch3", 64'(exp_clks[3]), 64'(4'b0011));

        // Asynchronous reset mid-operation clears outputs without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        chan_en = '0;
        step();
        rst_n = 1'b1;
        step();
        chk_all_zero("after_async_reset");
        chan_en[1] = 1'b1;
        step();
        chk("restart_ch1", 64'(exp_clks[1]), 64'(4'b1101));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
